// File: rtl/match_controller.sv
// Game-flow controller for the N-player tank game: MENU -> PLAYING -> ROUND_OVER -> FINAL.
// Tracks the active/alive player masks and the per-player scores, and picks the round/match winner.
module match_controller #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 6,
  parameter int WIN_SCORE   = 5,
  parameter int HOLD_FRAMES = 60
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             frame_tick_i,
  input  logic                             start_i,
  input  logic                             select_up_i,
  input  logic                             select_down_i,
  input  logic [NUM_PLAYERS-1:0]           hit_i,
  output logic                             is_menu_o,
  output logic                             is_playing_o,
  output logic                             is_continue_o,
  output logic                             is_final_o,
  output logic                             round_reset_o,
  output logic [NUM_PLAYERS-1:0]           active_mask_o,
  output logic [NUM_PLAYERS-1:0]           alive_mask_o,
  output logic [NUM_PLAYERS*SCORE_W-1:0]   score_o,
  output logic [$clog2(NUM_PLAYERS)-1:0]   winner_o,
  output logic                             winner_valid_o
);

  localparam int WIN_W  = $clog2(NUM_PLAYERS);
  localparam int CNT_W  = $clog2(NUM_PLAYERS + 1);
  localparam int HOLD_W = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

  localparam logic [SCORE_W-1:0]     SCORE_MAX  = {SCORE_W{1'b1}};
  localparam logic [SCORE_W-1:0]     WIN_S      = SCORE_W'(WIN_SCORE);
  localparam logic [HOLD_W-1:0]      HOLD_CAP   = HOLD_W'(HOLD_FRAMES);
  localparam logic [CNT_W-1:0]       CNT_MIN    = CNT_W'(2);
  localparam logic [CNT_W-1:0]       CNT_MAX    = CNT_W'(NUM_PLAYERS);
  localparam logic [NUM_PLAYERS-1:0] RESET_MASK = NUM_PLAYERS'(2'b11);

  // One-hot encoding lets each state flag come straight off a state register bit.
  typedef enum logic [3:0] {
    S_MENU       = 4'b0001,
    S_PLAYING    = 4'b0010,
    S_ROUND_OVER = 4'b0100,
    S_FINAL      = 4'b1000
  } state_t;

  state_t                   r_state;
  logic [CNT_W-1:0]         r_count;
  logic [NUM_PLAYERS-1:0]   r_active_mask;
  logic [NUM_PLAYERS-1:0]   r_alive_mask;
  logic [SCORE_W-1:0]       r_score [NUM_PLAYERS];
  logic [WIN_W-1:0]         r_winner;
  logic                     r_winner_valid;
  logic [HOLD_W-1:0]        r_hold;
  logic                     r_round_reset;
  logic                     r_start_q;
  logic                     r_up_q;
  logic                     r_down_q;
  logic [NUM_PLAYERS-1:0]   r_hit_q;

  logic                     w_start_rise;
  logic                     w_up_rise;
  logic                     w_down_rise;
  logic [NUM_PLAYERS-1:0]   w_hit_rise;
  logic [NUM_PLAYERS-1:0]   w_alive_next;
  logic [CNT_W-1:0]         w_pop;
  logic [WIN_W-1:0]         w_win_idx;
  logic [SCORE_W-1:0]       w_win_score;
  logic [SCORE_W-1:0]       w_score_inc;
  logic [CNT_W-1:0]         w_count_next;
  logic [NUM_PLAYERS-1:0]   w_mask_next;

  assign w_start_rise = start_i & ~r_start_q;
  assign w_up_rise    = select_up_i & ~r_up_q;
  assign w_down_rise  = select_down_i & ~r_down_q;
  assign w_hit_rise   = hit_i & ~r_hit_q;

  // Only hits on players that are both in the match and still alive take effect.
  assign w_alive_next = r_alive_mask & ~(w_hit_rise & r_active_mask);

  always_comb begin
    w_pop     = '0;
    w_win_idx = '0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      if (w_alive_next[p]) begin
        w_pop     = w_pop + CNT_W'(1);
        w_win_idx = WIN_W'(p);
      end
    end
    w_win_score = r_score[w_win_idx];
    w_score_inc = (w_win_score == SCORE_MAX) ? SCORE_MAX : w_win_score + SCORE_W'(1);
  end

  always_comb begin
    w_count_next = r_count;
    if (w_up_rise && !w_down_rise && r_count < CNT_MAX)
      w_count_next = r_count + CNT_W'(1);
    else if (w_down_rise && !w_up_rise && r_count > CNT_MIN)
      w_count_next = r_count - CNT_W'(1);
    w_mask_next = '0;
    for (int p = 0; p < NUM_PLAYERS; p++)
      w_mask_next[p] = (p < int'(w_count_next));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state        <= S_MENU;
      r_count        <= CNT_MIN;
      r_active_mask  <= RESET_MASK;
      r_alive_mask   <= RESET_MASK;
      for (int p = 0; p < NUM_PLAYERS; p++) r_score[p] <= '0;
      r_winner       <= '0;
      r_winner_valid <= 1'b0;
      r_hold         <= '0;
      r_round_reset  <= 1'b1;
      r_start_q      <= 1'b0;
      r_up_q         <= 1'b0;
      r_down_q       <= 1'b0;
      r_hit_q        <= '0;
    end else begin
      r_start_q <= start_i;
      r_up_q    <= select_up_i;
      r_down_q  <= select_down_i;
      r_hit_q   <= hit_i;
      case (r_state)
        S_MENU: begin
          r_count       <= w_count_next;
          r_active_mask <= w_mask_next;
          r_alive_mask  <= w_mask_next;
          if (w_start_rise) begin
            r_state        <= S_PLAYING;
            r_round_reset  <= 1'b0;
            r_winner_valid <= 1'b0;
            for (int p = 0; p < NUM_PLAYERS; p++) r_score[p] <= '0;
          end
        end
        S_PLAYING: begin
          r_alive_mask <= w_alive_next;
          if (w_pop == CNT_W'(1)) begin
            r_score[w_win_idx] <= w_score_inc;
            r_winner           <= w_win_idx;
            r_winner_valid     <= 1'b1;
            r_hold             <= '0;
            r_round_reset      <= 1'b1;
            r_state            <= (w_score_inc >= WIN_S) ? S_FINAL : S_ROUND_OVER;
          end else if (w_pop == '0) begin
            r_winner_valid <= 1'b0;
            r_hold         <= '0;
            r_round_reset  <= 1'b1;
            r_state        <= S_ROUND_OVER;
          end
        end
        S_ROUND_OVER: begin
          if (frame_tick_i && r_hold != HOLD_CAP)
            r_hold <= r_hold + HOLD_W'(1);
          // The start check uses the pre-increment count, so a press on the last tick is dropped.
          if (w_start_rise && r_hold == HOLD_CAP) begin
            r_state       <= S_PLAYING;
            r_alive_mask  <= r_active_mask;
            r_round_reset <= 1'b0;
          end
        end
        S_FINAL: begin
          if (w_start_rise) begin
            r_state       <= S_MENU;
            r_round_reset <= 1'b1;
          end
        end
        default: begin
          r_state       <= S_MENU;
          r_round_reset <= 1'b1;
        end
      endcase
    end
  end

  assign is_menu_o      = r_state[0];
  assign is_playing_o   = r_state[1];
  assign is_continue_o  = r_state[2];
  assign is_final_o     = r_state[3];
  assign round_reset_o  = r_round_reset;
  assign active_mask_o  = r_active_mask;
  assign alive_mask_o   = r_alive_mask;
  assign winner_o       = r_winner;
  assign winner_valid_o = r_winner_valid;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PLAYERS; gi++) begin : g_score_pack
      assign score_o[gi*SCORE_W +: SCORE_W] = r_score[gi];
    end
  endgenerate

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller built with 4 player slots, 6-bit scores,
// a 5-point match and a 60-frame hold.
module tb_match_controller;
  localparam int N  = 4;
  localparam int SW = 6;

  localparam logic [3:0] F_MENU  = 4'b0001;
  localparam logic [3:0] F_PLAY  = 4'b0010;
  localparam logic [3:0] F_CONT  = 4'b0100;
  localparam logic [3:0] F_FINAL = 4'b1000;

  logic          clk = 1'b0;
  logic          reset, frame_tick, start, up, down;
  logic [N-1:0]  hit;
  logic          is_menu, is_playing, is_continue, is_final, round_reset;
  logic [N-1:0]  active_mask, alive_mask;
  logic [N*SW-1:0] score;
  logic [1:0]    winner;
  logic          winner_valid;
  logic [3:0]    flags;

  int vectors = 0;
  int miscompares = 0;

  assign flags = {is_final, is_continue, is_playing, is_menu};

  always #5 clk = ~clk;

  match_controller #(
    .NUM_PLAYERS(N), .SCORE_W(SW), .WIN_SCORE(5), .HOLD_FRAMES(60)
  ) dut (
    .clk_i(clk), .reset_i(reset), .frame_tick_i(frame_tick), .start_i(start),
    .select_up_i(up), .select_down_i(down), .hit_i(hit),
    .is_menu_o(is_menu), .is_playing_o(is_playing), .is_continue_o(is_continue),
    .is_final_o(is_final), .round_reset_o(round_reset), .active_mask_o(active_mask),
    .alive_mask_o(alive_mask), .score_o(score), .winner_o(winner),
    .winner_valid_o(winner_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; tick();
      frame_tick = 1'b0; tick();
    end
  endtask

  function automatic logic [N*SW-1:0] pack_p1(input int s1);
    logic [N*SW-1:0] v;
    v = '0;
    v[SW +: SW] = SW'(s1);
    return v;
  endfunction

  task automatic test_reset();
    reset = 1'b1; frame_tick = 0; start = 0; up = 0; down = 0; hit = '0;
    tick(); tick();
    reset = 1'b0;
    vectors++; if (flags !== F_MENU) begin miscompares++; $display("FAIL reset_flags: got %b expected %b", flags, F_MENU); end
    vectors++; if (round_reset !== 1'b1) begin miscompares++; $display("FAIL reset_round_reset: got %b expected 1", round_reset); end
    vectors++; if (score !== '0) begin miscompares++; $display("FAIL reset_score: got %h expected 0", score); end
    vectors++; if (active_mask !== 4'b0011) begin miscompares++; $display("FAIL reset_active: got %b expected 0011", active_mask); end
    vectors++; if (alive_mask !== 4'b0011) begin miscompares++; $display("FAIL reset_alive: got %b expected 0011", alive_mask); end
    vectors++; if (winner_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b expected 0", winner_valid); end
    $display("test_reset done");
  endtask

  task automatic test_round_win();
    start = 1'b1; tick(); start = 1'b0;
    vectors++; if (flags !== F_PLAY) begin miscompares++; $display("FAIL start_flags: got %b expected %b", flags, F_PLAY); end
    vectors++; if (round_reset !== 1'b0) begin miscompares++; $display("FAIL start_round_reset: got %b expected 0", round_reset); end
    tick();
    hit = 4'b0001; tick();
    vectors++; if (flags !== F_CONT) begin miscompares++; $display("FAIL win_flags: got %b expected %b", flags, F_CONT); end
    vectors++; if (alive_mask !== 4'b0010) begin miscompares++; $display("FAIL win_alive: got %b expected 0010", alive_mask); end
    vectors++; if (winner !== 2'd1 || winner_valid !== 1'b1) begin miscompares++; $display("FAIL win_winner: got %0d/%b expected 1/1", winner, winner_valid); end
    vectors++; if (round_reset !== 1'b1) begin miscompares++; $display("FAIL win_round_reset: got %b expected 1", round_reset); end
    repeat (9) tick();
    vectors++; if (score !== pack_p1(1)) begin miscompares++; $display("FAIL win_score_once: got %h expected %h", score, pack_p1(1)); end
    hit = '0; tick();
    $display("test_round_win done");
  endtask

  task automatic test_hold();
    start = 1'b1; tick(); start = 1'b0; tick();
    vectors++; if (flags !== F_CONT) begin miscompares++; $display("FAIL hold_early0: got %b expected %b", flags, F_CONT); end
    tick_frames(59);
    start = 1'b1; tick(); start = 1'b0; tick();
    vectors++; if (flags !== F_CONT) begin miscompares++; $display("FAIL hold_early59: got %b expected %b", flags, F_CONT); end
    tick_frames(4);
    start = 1'b1; tick(); start = 1'b0;
    vectors++; if (flags !== F_PLAY) begin miscompares++; $display("FAIL hold_accept: got %b expected %b", flags, F_PLAY); end
    vectors++; if (alive_mask !== 4'b0011) begin miscompares++; $display("FAIL hold_alive: got %b expected 0011", alive_mask); end
    vectors++; if (score !== pack_p1(1)) begin miscompares++; $display("FAIL hold_score_kept: got %h expected %h", score, pack_p1(1)); end
    tick();
    $display("test_hold done");
  endtask

  task automatic test_win_match();
    for (int r = 2; r <= 4; r++) begin
      hit = 4'b0001; tick(); hit = '0; tick();
      vectors++; if (flags !== F_CONT || score !== pack_p1(r)) begin miscompares++; $display("FAIL match_round%0d: got %b/%h expected %b/%h", r, flags, score, F_CONT, pack_p1(r)); end
      tick_frames(60);
      start = 1'b1; tick(); start = 1'b0; tick();
    end
    hit = 4'b0001; tick(); hit = '0; tick();
    vectors++; if (flags !== F_FINAL) begin miscompares++; $display("FAIL final_flags: got %b expected %b", flags, F_FINAL); end
    vectors++; if (winner !== 2'd1 || winner_valid !== 1'b1) begin miscompares++; $display("FAIL final_winner: got %0d/%b expected 1/1", winner, winner_valid); end
    vectors++; if (score !== pack_p1(5)) begin miscompares++; $display("FAIL final_score: got %h expected %h", score, pack_p1(5)); end
    hit = 4'b0010; tick(); hit = '0; tick();
    up = 1'b1; tick(); up = 1'b0; tick();
    tick_frames(2);
    vectors++; if (flags !== F_FINAL || score !== pack_p1(5) || active_mask !== 4'b0011) begin miscompares++; $display("FAIL final_ignore: got %b/%h/%b expected %b/%h/0011", flags, score, active_mask, F_FINAL, pack_p1(5)); end
    start = 1'b1; tick(); start = 1'b0;
    vectors++; if (flags !== F_MENU || round_reset !== 1'b1) begin miscompares++; $display("FAIL final_to_menu: got %b/%b expected %b/1", flags, round_reset, F_MENU); end
    vectors++; if (score !== pack_p1(5)) begin miscompares++; $display("FAIL menu_score_visible: got %h expected %h", score, pack_p1(5)); end
    tick();
    $display("test_win_match done");
  endtask

  task automatic test_draw();
    up = 1'b1; tick(); up = 1'b0; tick();
    vectors++; if (active_mask !== 4'b0111) begin miscompares++; $display("FAIL draw_active: got %b expected 0111", active_mask); end
    start = 1'b1; tick(); start = 1'b0;
    vectors++; if (score !== '0 || winner_valid !== 1'b0) begin miscompares++; $display("FAIL new_match_clear: got %h/%b expected 0/0", score, winner_valid); end
    tick();
    hit = 4'b1000; tick(); hit = '0; tick();
    vectors++; if (alive_mask !== 4'b0111 || flags !== F_PLAY) begin miscompares++; $display("FAIL inactive_hit: got %b/%b expected 0111/%b", alive_mask, flags, F_PLAY); end
    hit = 4'b0001; tick(); hit = '0; tick();
    vectors++; if (alive_mask !== 4'b0110 || flags !== F_PLAY) begin miscompares++; $display("FAIL draw_setup: got %b/%b expected 0110/%b", alive_mask, flags, F_PLAY); end
    hit = 4'b0110; tick();
    vectors++; if (flags !== F_CONT || winner_valid !== 1'b0 || score !== '0) begin miscompares++; $display("FAIL draw_result: got %b/%b/%h expected %b/0/0", flags, winner_valid, score, F_CONT); end
    hit = '0; tick();
    $display("test_draw done");
  endtask

  task automatic test_reset_midmatch();
    tick_frames(60);
    start = 1'b1; tick(); start = 1'b0; tick();
    hit = 4'b0001; tick(); hit = '0;
    reset = 1'b1; tick(); reset = 1'b0;
    vectors++; if (flags !== F_MENU || round_reset !== 1'b1) begin miscompares++; $display("FAIL midreset_flags: got %b/%b expected %b/1", flags, round_reset, F_MENU); end
    vectors++; if (active_mask !== 4'b0011 || alive_mask !== 4'b0011) begin miscompares++; $display("FAIL midreset_masks: got %b/%b expected 0011/0011", active_mask, alive_mask); end
    tick();
    $display("test_reset_midmatch done");
  endtask

  task automatic test_menu_n4();
    down = 1'b1; tick(); down = 1'b0; tick();
    vectors++; if (active_mask !== 4'b0011) begin miscompares++; $display("FAIL menu_down_sat: got %b expected 0011", active_mask); end
    up = 1'b1; tick(); tick(); tick(); up = 1'b0; tick();
    vectors++; if (active_mask !== 4'b0111) begin miscompares++; $display("FAIL menu_up_held: got %b expected 0111", active_mask); end
    up = 1'b1; tick(); up = 1'b0; tick();
    up = 1'b1; tick(); up = 1'b0; tick();
    vectors++; if (active_mask !== 4'b1111) begin miscompares++; $display("FAIL menu_up_sat: got %b expected 1111", active_mask); end
    up = 1'b1; down = 1'b1; tick(); up = 1'b0; down = 1'b0; tick();
    vectors++; if (active_mask !== 4'b1111) begin miscompares++; $display("FAIL menu_up_down: got %b expected 1111", active_mask); end
    down = 1'b1; tick(); down = 1'b0; tick();
    vectors++; if (active_mask !== 4'b0111) begin miscompares++; $display("FAIL menu_down: got %b expected 0111", active_mask); end
    up = 1'b1; tick(); up = 1'b0; tick();
    start = 1'b1; tick(); start = 1'b0;
    vectors++; if (flags !== F_PLAY || round_reset !== 1'b0 || alive_mask !== 4'b1111) begin miscompares++; $display("FAIL n4_start: got %b/%b/%b expected %b/0/1111", flags, round_reset, alive_mask, F_PLAY); end
    tick();
    hit = 4'b0111; tick(); hit = '0;
    vectors++; if (winner !== 2'd3 || winner_valid !== 1'b1 || score[3*SW +: SW] !== 6'd1) begin miscompares++; $display("FAIL n4_winner: got %0d/%b/%0d expected 3/1/1", winner, winner_valid, score[3*SW +: SW]); end
    tick();
    $display("test_menu_n4 done");
  endtask

  initial begin
    test_reset();
    test_round_win();
    test_hold();
    test_win_match();
    test_draw();
    test_reset_midmatch();
    test_menu_n4();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
